// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates IF/ME word requests onto one byte-wide memory port
// Optional MEM_ARBITER_RR_EN: round-robin tie-break instead of fixed ME priority.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_r_enable_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_busy_o,
    output logic        if_done_o,
    input  logic        ram_r_enable_i,
    input  logic        ram_w_enable_i,
    input  logic [3:0]  ram_w_mask_i,
    input  logic [31:0] ram_w_data_i,
    input  logic [31:0] ram_addr_i,
    output logic [31:0] ram_r_data_o,
    output logic        ram_busy_o,
    output logic        ram_done_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [7:0]  mem_dout_o,
    input  logic [7:0]  mem_din_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_ME} owner_t;

    state_t      state, state_nxt;
    owner_t      owner, owner_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [29:0] base_q, base_nxt;
    logic        wr_q, wr_nxt;
    logic [3:0]  mask_q, mask_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [23:0] rbuf_q, rbuf_nxt;
    logic [31:0] if_data_q, if_data_nxt;
    logic [31:0] ram_data_q, ram_data_nxt;

    logic        if_req, me_req, grant_me, in_access;
    logic [31:0] word_done;
    logic        unused_addr_bits;

    assign if_req           = if_r_enable_i;
    assign me_req           = ram_r_enable_i | ram_w_enable_i;
    assign unused_addr_bits = ^{if_addr_i[1:0], ram_addr_i[1:0]};
    // The top byte arrives on mem_din_i during DONE itself.
    assign word_done        = {mem_din_i, rbuf_q};

`ifdef MEM_ARBITER_RR_EN
    // Flips only on contested grants; starts so that ME takes the first tie.
    logic me_won_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            me_won_last <= 1'b0;
        else if (state == IDLE && if_req && me_req)
            me_won_last <= grant_me;
    end

    assign grant_me = me_req && (!if_req || !me_won_last);
`else
    assign grant_me = me_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            cnt        <= 2'd0;
            base_q     <= 30'd0;
            wr_q       <= 1'b0;
            mask_q     <= 4'd0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 24'd0;
            if_data_q  <= 32'd0;
            ram_data_q <= 32'd0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            cnt        <= cnt_nxt;
            base_q     <= base_nxt;
            wr_q       <= wr_nxt;
            mask_q     <= mask_nxt;
            wdata_q    <= wdata_nxt;
            rbuf_q     <= rbuf_nxt;
            if_data_q  <= if_data_nxt;
            ram_data_q <= ram_data_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        cnt_nxt      = cnt;
        base_nxt     = base_q;
        wr_nxt       = wr_q;
        mask_nxt     = mask_q;
        wdata_nxt    = wdata_q;
        rbuf_nxt     = rbuf_q;
        if_data_nxt  = if_data_q;
        ram_data_nxt = ram_data_q;
        case (state)
            IDLE: begin
                if (if_req || me_req) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = 2'd0;
                    if (grant_me) begin
                        owner_nxt = OWN_ME;
                        base_nxt  = ram_addr_i[31:2];
                        wr_nxt    = ram_w_enable_i;
                        mask_nxt  = ram_w_mask_i;
                        wdata_nxt = ram_w_data_i;
                    end else begin
                        owner_nxt = OWN_IF;
                        base_nxt  = if_addr_i[31:2];
                        wr_nxt    = 1'b0;
                        mask_nxt  = 4'd0;
                        wdata_nxt = 32'd0;
                    end
                end
            end
            ACCESS: begin
                // Byte cnt-1 was addressed last cycle and is on mem_din_i now.
                case (cnt)
                    2'd1:    rbuf_nxt[7:0]   = mem_din_i;
                    2'd2:    rbuf_nxt[15:8]  = mem_din_i;
                    2'd3:    rbuf_nxt[23:16] = mem_din_i;
                    default: ;
                endcase
                cnt_nxt = cnt + 2'd1;
                if (cnt == 2'd3)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
                if (!wr_q) begin
                    if (owner == OWN_IF)
                        if_data_nxt = word_done;
                    else
                        ram_data_nxt = word_done;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

    assign in_access    = (state == ACCESS);
    assign mem_addr_o   = in_access ? {base_q, cnt} : 32'd0;
    assign mem_wr_o     = in_access && wr_q && mask_q[cnt];
    assign mem_dout_o   = (in_access && wr_q) ? wdata_q[{cnt, 3'b000} +: 8] : 8'd0;

    assign if_done_o    = (state == DONE) && (owner == OWN_IF);
    assign ram_done_o   = (state == DONE) && (owner == OWN_ME);
    assign if_data_o    = if_done_o ? word_done : if_data_q;
    assign ram_r_data_o = (ram_done_o && !wr_q) ? word_done : ram_data_q;

    // Busy drops in the done cycle even though the owner is still set.
    assign if_busy_o  = rst && (((owner == OWN_IF) && in_access) ||
                                (if_req && (owner != OWN_IF)));
    assign ram_busy_o = rst && (((owner == OWN_ME) && in_access) ||
                                (me_req && (owner != OWN_ME)));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with byte-memory reference
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_r_enable_i = 1'b0;
    logic [31:0] if_addr_i = 32'd0;
    logic [31:0] if_data_o;
    logic        if_busy_o, if_done_o;
    logic        ram_r_enable_i = 1'b0;
    logic        ram_w_enable_i = 1'b0;
    logic [3:0]  ram_w_mask_i = 4'd0;
    logic [31:0] ram_w_data_i = 32'd0;
    logic [31:0] ram_addr_i = 32'd0;
    logic [31:0] ram_r_data_o;
    logic        ram_busy_o, ram_done_o;
    logic [31:0] mem_addr_o;
    logic        mem_wr_o;
    logic [7:0]  mem_dout_o;
    logic [7:0]  mem_din_i = 8'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic        mem_init = 1'b0;
    logic [31:0] last_me_read = 32'd0;
    logic [31:0] if_q[$];
    logic [31:0] me_q[$];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_r_enable_i(if_r_enable_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .if_busy_o(if_busy_o), .if_done_o(if_done_o),
        .ram_r_enable_i(ram_r_enable_i), .ram_w_enable_i(ram_w_enable_i),
        .ram_w_mask_i(ram_w_mask_i), .ram_w_data_i(ram_w_data_i), .ram_addr_i(ram_addr_i),
        .ram_r_data_o(ram_r_data_o), .ram_busy_o(ram_busy_o), .ram_done_o(ram_done_o),
        .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o), .mem_dout_o(mem_dout_o),
        .mem_din_i(mem_din_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            'h104:   return 8'h13;
            'h105:   return 8'h05;
            'h106:   return 8'h10;
            'h107:   return 8'h00;
            default: return 8'(i * 7 + (i >> 4) + 3);
        endcase
    endfunction

    // Synchronous byte memory: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i);
            mem_init <= 1'b1;
        end else if (mem_wr_o) begin
            mem[mem_addr_o[9:0]] <= mem_dout_o;
        end
        mem_din_i <= mem[mem_addr_o[9:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic if_push(input logic [31:0] a);
        logic [31:0] e;
        logic [9:0]  idx;
        for (int k = 0; k < 4; k++) begin
            idx = {a[9:2], 2'(k)};
            e[8*k +: 8] = ref_mem[idx];
        end
        if_q.push_back(e);
    endtask

    task automatic me_push(input logic [31:0] a, input bit w, input logic [3:0] m,
                           input logic [31:0] d);
        logic [31:0] e;
        logic [9:0]  idx;
        e = 32'd0;
        for (int k = 0; k < 4; k++) begin
            idx = {a[9:2], 2'(k)};
            if (w) begin
                if (m[k]) ref_mem[idx] = d[8*k +: 8];
            end else begin
                e[8*k +: 8] = ref_mem[idx];
            end
        end
        if (w) e = last_me_read;
        else last_me_read = e;
        me_q.push_back(e);
    endtask

    // Monitor: busy rule every cycle, data popped from the scoreboard on each done.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("if_busy", if_busy_o, if_r_enable_i && !if_done_o);
                check("ram_busy", ram_busy_o, (ram_r_enable_i || ram_w_enable_i) && !ram_done_o);
                if (if_done_o) begin
                    if (if_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL if_extra_done: got done=1 expected no pending IF request (cycle %0d)", cyc);
                    end else begin
                        e = if_q.pop_front();
                        check("if_data", if_data_o, e);
                    end
                end
                if (ram_done_o) begin
                    if (me_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ram_extra_done: got done=1 expected no pending ME request (cycle %0d)", cyc);
                    end else begin
                        e = me_q.pop_front();
                        check("ram_data", ram_r_data_o, e);
                    end
                end
            end
        end
    end

    task automatic wait_done(input bit me);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(me ? ram_done_o : if_done_o) && n < 30);
        if (n >= 30) check(me ? "ram_done_timeout" : "if_done_timeout", 0, 1);
    endtask

    // Single uncontested transaction with per-cycle checks of the byte sequence.
    task automatic run_one(input bit me, input logic [31:0] a, input bit w, input bit r,
                           input logic [3:0] m, input logic [31:0] d);
        logic [31:0] base;
        bit          strobe;
        base = {a[31:2], 2'b00};
        if (me) me_push(a, w, m, d);
        else if_push(a);
        @(posedge clk); #1;
        if (me) begin
            ram_addr_i = a; ram_w_enable_i = w; ram_r_enable_i = r;
            ram_w_mask_i = m; ram_w_data_i = d;
        end else begin
            if_addr_i = a; if_r_enable_i = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            strobe = me && w && m[k];
            check("mem_addr", mem_addr_o, base + 32'(k));
            check("mem_wr", mem_wr_o, strobe);
            if (strobe) check("mem_dout", mem_dout_o, d[8*k +: 8]);
        end
        @(negedge clk);
        check(me ? "ram_done_t5" : "if_done_t5", me ? ram_done_o : if_done_o, 1);
        check("mem_addr_idle", mem_addr_o, 0);
        @(posedge clk); #1;
        if_r_enable_i = 1'b0; ram_r_enable_i = 1'b0; ram_w_enable_i = 1'b0;
    endtask

    task automatic tie_test(input bit me_first);
        int t0, ifd, med;
        ifd = -1; med = -1;
        if_push(32'h0000_0040);
        me_push(32'h0000_0284, 1'b0, 4'd0, 32'd0);
        @(posedge clk); #1;
        t0 = cyc;
        if_addr_i = 32'h0000_0040; if_r_enable_i = 1'b1;
        ram_addr_i = 32'h0000_0284; ram_r_enable_i = 1'b1; ram_w_enable_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (if_done_o && ifd < 0) ifd = cyc - t0;
            if (ram_done_o && med < 0) med = cyc - t0;
            @(posedge clk); #1;
            if (ifd >= 0) if_r_enable_i = 1'b0;
            if (med >= 0) ram_r_enable_i = 1'b0;
        end
        if_r_enable_i = 1'b0; ram_r_enable_i = 1'b0;
        check("tie_ram_done_cycle", med, me_first ? 5 : 11);
        check("tie_if_done_cycle", ifd, me_first ? 11 : 5);
    endtask

    initial begin
        int t0, d1, d2;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_data", if_data_o, 0);
        check("rst_ram_data", ram_r_data_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_outs", {if_busy_o, if_done_o, ram_busy_o, ram_done_o, mem_wr_o, mem_dout_o}, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_one(1'b0, 32'h0000_0104, 1'b0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        check("if_word_held", if_data_o, 32'h0010_0513);
        run_one(1'b1, 32'h0000_0203, 1'b1, 1'b0, 4'b0100, 32'hAABB_CCDD);
        run_one(1'b1, 32'h0000_0210, 1'b1, 1'b0, 4'b0000, 32'h1122_3344);
        run_one(1'b1, 32'h0000_0220, 1'b1, 1'b1, 4'b1111, 32'hDEAD_BEEF);
        run_one(1'b1, 32'h0000_0220, 1'b0, 1'b1, 4'd0, 32'd0);
        run_one(1'b1, 32'h0000_0200, 1'b0, 1'b1, 4'd0, 32'd0);
        run_one(1'b1, 32'h0000_0230, 1'b1, 1'b1, 4'b1010, 32'h5566_7788);
        check("ram_data_after_store", ram_r_data_o, last_me_read);

        tie_test(1'b1);
`ifdef MEM_ARBITER_RR_EN
        tie_test(1'b0);
`else
        tie_test(1'b1);
`endif

        me_push(32'h0000_0240, 1'b0, 4'd0, 32'd0);
        me_push(32'h0000_0240, 1'b0, 4'd0, 32'd0);
        @(posedge clk); #1;
        t0 = cyc; d1 = -1; d2 = -1;
        ram_addr_i = 32'h0000_0240; ram_r_enable_i = 1'b1; ram_w_enable_i = 1'b0;
        for (int i = 0; i < 16 && d2 < 0; i++) begin
            @(negedge clk);
            if (ram_done_o) begin
                if (d1 < 0) d1 = cyc - t0;
                else d2 = cyc - t0;
            end
        end
        @(posedge clk); #1;
        ram_r_enable_i = 1'b0;
        check("b2b_first_done", d1, 5);
        check("b2b_second_done", d2, 11);

        @(posedge clk); #1;
        if_addr_i = 32'h0000_01A0; if_r_enable_i = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0; if_r_enable_i = 1'b0;
        @(negedge clk);
        check("midrst_if_data", if_data_o, 0);
        check("midrst_ram_data", ram_r_data_o, 0);
        check("midrst_mem_addr", mem_addr_o, 0);
        check("midrst_outs", {if_busy_o, if_done_o, ram_busy_o, ram_done_o, mem_wr_o, mem_dout_o}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        last_me_read = 32'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_done", if_done_o, 0);
        end
        run_one(1'b0, 32'h0000_01A4, 1'b0, 1'b0, 4'd0, 32'd0);

        fork
            begin : if_driver
                logic [31:0] a;
                for (int n = 0; n < 30; n++) begin
                    a = $urandom();
                    a[9] = 1'b0;
                    if_push(a);
                    @(posedge clk); #1;
                    if_addr_i = a; if_r_enable_i = 1'b1;
                    wait_done(1'b0);
                    @(posedge clk); #1;
                    if_r_enable_i = 1'b0;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin : me_driver
                logic [31:0] a, d;
                logic [3:0]  m;
                bit          w, r;
                for (int n = 0; n < 30; n++) begin
                    a = $urandom();
                    a[9] = 1'b1;
                    d = $urandom();
                    m = 4'($urandom());
                    w = 1'($urandom_range(0, 1));
                    r = w ? 1'($urandom_range(0, 1)) : 1'b1;
                    me_push(a, w, m, d);
                    @(posedge clk); #1;
                    ram_addr_i = a; ram_w_data_i = d; ram_w_mask_i = m;
                    ram_w_enable_i = w; ram_r_enable_i = r;
                    wait_done(1'b1);
                    @(posedge clk); #1;
                    ram_w_enable_i = 1'b0; ram_r_enable_i = 1'b0;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("if_q_drained", if_q.size(), 0);
        check("me_q_drained", me_q.size(), 0);
        for (int i = 'h200; i < 'h400; i++) check("mem_contents", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "watchdog");
    end
endmodule
